// File: rtl/axi_res_arb.sv
// Sequencer/arbiter in front of the AXI reservation table: serializes LR set
// requests and store check/clear requests, returns the check result to the write path.
module axi_res_arb #(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned MAX_STARVE     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      lr_valid_i,
  output logic                      lr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
  input  logic                      st_valid_i,
  output logic                      st_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] st_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   st_id_i,
  input  logic                      st_excl_i,
  output logic                      st_rsp_valid_o,
  input  logic                      st_rsp_ready_i,
  output logic                      st_rsp_ok_o,
  output logic [AXI_ID_WIDTH-1:0]   st_rsp_id_o,
  output logic                      check_clr_req_o,
  input  logic                      check_clr_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0] check_clr_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   check_id_o,
  output logic                      check_clr_excl_o,
  input  logic                      check_res_i,
  output logic                      set_req_o,
  input  logic                      set_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0] set_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   set_id_o
);

  localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CHK  = 2'd1;
  localparam logic [1:0] SET  = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]                state_q;
  logic [CNT_W-1:0]          starve_cnt_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      excl_q;
  logic                      ok_q;
  logic                      idle;
  logic                      starve;

  assign idle   = (state_q == IDLE);
  assign starve = (starve_cnt_q == STARVE_LIMIT);

  // Ready is a function of state, starve count and valids only, so there is
  // no combinational path from the table grants back to the requesters.
  assign st_ready_o = idle & st_valid_i & ~(lr_valid_i & starve);
  assign lr_ready_o = idle & lr_valid_i & (~st_valid_i | starve);

  assign check_clr_req_o  = (state_q == CHK);
  assign set_req_o        = (state_q == SET);
  assign st_rsp_valid_o   = (state_q == RSP);
  assign check_clr_addr_o = addr_q;
  assign check_id_o       = id_q;
  assign check_clr_excl_o = excl_q;
  assign set_addr_o       = addr_q;
  assign set_id_o         = id_q;
  assign st_rsp_ok_o      = ok_q;
  assign st_rsp_id_o      = id_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across always_ff blocks.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      excl_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_ready_o) begin
            state_q <= CHK;
            addr_q  <= st_addr_i;
            id_q    <= st_id_i;
            excl_q  <= st_excl_i;
          end else if (lr_ready_o) begin
            state_q <= SET;
            addr_q  <= lr_addr_i;
            id_q    <= lr_id_i;
            excl_q  <= 1'b0;
          end
        end
        CHK: begin
          if (check_clr_gnt_i) begin
            state_q <= RSP;
            ok_q    <= check_res_i;
          end
        end
        SET: if (set_gnt_i) state_q <= IDLE;
        RSP: if (st_rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counts store wins while an LR is waiting; held while an op is in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (lr_ready_o || (idle && !lr_valid_i)) begin
      starve_cnt_q <= '0;
    end else if (st_ready_o && !starve) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_res_arb.sv
// Self-checking bench for axi_res_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_axi_res_arb;

  localparam int AW = 16;
  localparam int IW = 4;
  localparam int MS = 4;
  localparam int OW = 7 + 3 * IW + 2 * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lr_valid, st_valid, st_excl, st_rsp_ready;
  logic          check_clr_gnt, check_res, set_gnt;
  logic [AW-1:0] lr_addr, st_addr;
  logic [IW-1:0] lr_id, st_id;
  logic          lr_ready_o, st_ready_o, st_rsp_valid_o, st_rsp_ok_o;
  logic          check_clr_req_o, check_clr_excl_o, set_req_o;
  logic [IW-1:0] st_rsp_id_o, check_id_o, set_id_o;
  logic [AW-1:0] check_clr_addr_o, set_addr_o;
  logic [OW-1:0] all_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_res_arb #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .MAX_STARVE(MS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lr_valid_i(lr_valid), .lr_ready_o(lr_ready_o), .lr_addr_i(lr_addr), .lr_id_i(lr_id),
    .st_valid_i(st_valid), .st_ready_o(st_ready_o), .st_addr_i(st_addr), .st_id_i(st_id),
    .st_excl_i(st_excl),
    .st_rsp_valid_o(st_rsp_valid_o), .st_rsp_ready_i(st_rsp_ready),
    .st_rsp_ok_o(st_rsp_ok_o), .st_rsp_id_o(st_rsp_id_o),
    .check_clr_req_o(check_clr_req_o), .check_clr_gnt_i(check_clr_gnt),
    .check_clr_addr_o(check_clr_addr_o), .check_id_o(check_id_o),
    .check_clr_excl_o(check_clr_excl_o), .check_res_i(check_res),
    .set_req_o(set_req_o), .set_gnt_i(set_gnt), .set_addr_o(set_addr_o), .set_id_o(set_id_o)
  );

  assign all_out = {lr_ready_o, st_ready_o, st_rsp_valid_o, st_rsp_ok_o, st_rsp_id_o,
                    check_clr_req_o, check_clr_addr_o, check_id_o, check_clr_excl_o,
                    set_req_o, set_addr_o, set_id_o};

  task automatic drive_idle();
    lr_valid = 0; lr_addr = '0; lr_id = '0;
    st_valid = 0; st_addr = '0; st_id = '0; st_excl = 0;
    st_rsp_ready = 0; check_clr_gnt = 0; check_res = 0; set_gnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1;
  endtask

  task automatic test_lone_lr();
    @(negedge clk);
    lr_valid = 1; lr_addr = 16'h1000; lr_id = 4'd3; set_gnt = 1;
    #1;
    n_cmp++;
    if ({lr_ready_o, st_ready_o} !== 2'b10) begin
      n_err++; $display("FAIL lr_accept: got %b expected 10", {lr_ready_o, st_ready_o});
    end
    @(negedge clk);
    lr_valid = 0;
    #1;
    n_cmp++;
    if ({set_req_o, set_addr_o, set_id_o, check_clr_req_o, lr_ready_o} !==
        {1'b1, 16'h1000, 4'd3, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL lr_set_req: got %b/%h/%h expected 1/1000/3", set_req_o, set_addr_o, set_id_o);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({set_req_o, check_clr_req_o, st_rsp_valid_o} !== 3'b000) begin
      n_err++; $display("FAIL lr_done: got %b expected 000", {set_req_o, check_clr_req_o, st_rsp_valid_o});
    end
    set_gnt = 0;
  endtask

  task automatic test_sc_after_lr();
    @(negedge clk);
    st_valid = 1; st_addr = 16'h1000; st_id = 4'd3; st_excl = 1;
    check_clr_gnt = 1; check_res = 1; st_rsp_ready = 0;
    #1;
    n_cmp++;
    if ({st_ready_o, lr_ready_o} !== 2'b10) begin
      n_err++; $display("FAIL sc_accept: got %b expected 10", {st_ready_o, lr_ready_o});
    end
    @(negedge clk);
    st_valid = 0;
    #1;
    n_cmp++;
    if ({check_clr_req_o, check_clr_excl_o, check_clr_addr_o, check_id_o, st_rsp_valid_o, set_req_o} !==
        {1'b1, 1'b1, 16'h1000, 4'd3, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sc_check_req: got req=%b excl=%b addr=%h id=%h expected 1/1/1000/3",
                        check_clr_req_o, check_clr_excl_o, check_clr_addr_o, check_id_o);
    end
    @(negedge clk);
    check_clr_gnt = 0; check_res = 0;
    #1;
    n_cmp++;
    if ({st_rsp_valid_o, st_rsp_ok_o, st_rsp_id_o, check_clr_req_o} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
      n_err++; $display("FAIL sc_rsp: got valid=%b ok=%b id=%h expected 1/1/3",
                        st_rsp_valid_o, st_rsp_ok_o, st_rsp_id_o);
    end
    st_rsp_ready = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (st_rsp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL sc_rsp_done: got %b expected 0", st_rsp_valid_o);
    end
  endtask

  task automatic test_starvation();
    logic found, got_lr;
    @(negedge clk);
    lr_valid = 1; lr_addr = 16'h0abc; lr_id = 4'd1;
    st_valid = 1; st_addr = 16'h0def; st_id = 4'd2; st_excl = 0;
    check_clr_gnt = 1; set_gnt = 1; st_rsp_ready = 1; check_res = 1;
    for (int k = 0; k < 6; k++) begin
      found = 0; got_lr = 0;
      for (int c = 0; c < 10; c++) begin
        #1;
        n_cmp++;
        if ((lr_ready_o & st_ready_o) !== 1'b0 || (check_clr_req_o & set_req_o) !== 1'b0) begin
          n_err++; $display("FAIL starve_exclusive: got rdy=%b%b req=%b%b expected no pair both 1",
                            lr_ready_o, st_ready_o, check_clr_req_o, set_req_o);
        end
        if (lr_ready_o || st_ready_o) begin
          found = 1; got_lr = lr_ready_o;
        end
        @(negedge clk);
        if (found) break;
      end
      n_cmp++;
      if (!found) begin
        n_err++; $display("FAIL starve_accept_%0d: got no accept within 10 cycles expected accept", k);
      end else if (got_lr !== (k == 4)) begin
        n_err++; $display("FAIL starve_accept_%0d: got lr=%b expected lr=%b", k, got_lr, (k == 4));
      end
    end
    lr_valid = 0; st_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({check_clr_req_o, set_req_o, st_rsp_valid_o} !== 3'b000) begin
      n_err++; $display("FAIL starve_drain: got %b expected 000", {check_clr_req_o, set_req_o, st_rsp_valid_o});
    end
  endtask

  task automatic test_stall();
    int rsp_cnt = 0;
    @(negedge clk);
    st_valid = 1; st_addr = 16'h2222; st_id = 4'd5; st_excl = 0;
    lr_valid = 0; check_clr_gnt = 0; set_gnt = 0; st_rsp_ready = 0;
    #1;
    n_cmp++;
    if (st_ready_o !== 1'b1) begin
      n_err++; $display("FAIL stall_accept: got %b expected 1", st_ready_o);
    end
    @(negedge clk);
    lr_valid = 1; lr_addr = 16'h3333; lr_id = 4'd1; st_addr = 16'h4444; st_id = 4'd6;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin check_clr_gnt = 1; check_res = 0; end
      #1;
      n_cmp++;
      if ({check_clr_req_o, check_clr_addr_o, check_id_o, check_clr_excl_o,
           st_rsp_valid_o, lr_ready_o, st_ready_o, set_req_o} !==
          {1'b1, 16'h2222, 4'd5, 1'b0, 4'b0000}) begin
        n_err++; $display("FAIL stall_chk_%0d: got req=%b addr=%h id=%h rdy=%b%b expected 1/2222/5/00",
                          i, check_clr_req_o, check_clr_addr_o, check_id_o, lr_ready_o, st_ready_o);
      end
      @(negedge clk);
    end
    check_clr_gnt = 0; check_res = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) st_rsp_ready = 1;
      #1;
      n_cmp++;
      if ({st_rsp_valid_o, st_rsp_ok_o, st_rsp_id_o, check_clr_req_o, lr_ready_o, st_ready_o} !==
          {1'b1, 1'b0, 4'd5, 3'b000}) begin
        n_err++; $display("FAIL stall_rsp_%0d: got valid=%b ok=%b id=%h rdy=%b%b expected 1/0/5/00",
                          i, st_rsp_valid_o, st_rsp_ok_o, st_rsp_id_o, lr_ready_o, st_ready_o);
      end
      if (st_rsp_valid_o && st_rsp_ready) rsp_cnt++;
      if (i == 3) begin lr_valid = 0; st_valid = 0; end
      @(negedge clk);
    end
    #1;
    if (st_rsp_valid_o && st_rsp_ready) rsp_cnt++;
    n_cmp++;
    if (rsp_cnt != 1 || st_rsp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL stall_rsp_count: got %0d (valid=%b) expected 1 (valid=0)", rsp_cnt, st_rsp_valid_o);
    end
    st_rsp_ready = 0;
  endtask

  task automatic test_simultaneous();
    logic saw_set = 0;
    logic acc;
    @(negedge clk);
    lr_valid = 1; lr_addr = 16'h5555; lr_id = 4'd2;
    st_valid = 1; st_addr = 16'h6666; st_id = 4'd7; st_excl = 1;
    check_clr_gnt = 1; set_gnt = 1; st_rsp_ready = 1;
    #1;
    n_cmp++;
    if ({st_ready_o, lr_ready_o} !== 2'b10) begin
      n_err++; $display("FAIL simul_first: got st/lr=%b expected 10", {st_ready_o, lr_ready_o});
    end
    @(negedge clk);
    st_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if ((check_clr_req_o & set_req_o) !== 1'b0) begin
        n_err++; $display("FAIL simul_req_exclusive: got chk=%b set=%b expected not both", check_clr_req_o, set_req_o);
      end
      if (set_req_o && set_addr_o == 16'h5555) saw_set = 1;
      acc = lr_ready_o;
      @(negedge clk);
      if (acc) lr_valid = 0;
    end
    n_cmp++;
    if (saw_set !== 1'b1) begin
      n_err++; $display("FAIL simul_lr_served: got %b expected 1", saw_set);
    end
  endtask

  task automatic test_reset_mid_op();
    logic rsp_seen = 0;
    @(negedge clk);
    drive_idle();
    st_valid = 1; st_addr = 16'h7777; st_id = 4'd9; st_excl = 1;
    #1;
    n_cmp++;
    if (st_ready_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_accept: got %b expected 1", st_ready_o);
    end
    @(negedge clk);
    st_valid = 0;
    #1;
    n_cmp++;
    if (check_clr_req_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_chk: got %b expected 1", check_clr_req_o);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++;
    if (all_out !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got %h expected 0", all_out);
    end
    check_clr_gnt = 1; check_res = 1; st_rsp_ready = 1;
    repeat (5) begin
      @(negedge clk);
      #1;
      rsp_seen = rsp_seen | st_rsp_valid_o | check_clr_req_o;
    end
    n_cmp++;
    if (rsp_seen !== 1'b0) begin
      n_err++; $display("FAIL midrst_dropped: got activity=%b expected 0", rsp_seen);
    end
    drive_idle();
  endtask

  // Transaction-level model: one outstanding op, and a count of stores that
  // won while an LR was waiting; the LR wins once that count reaches MS.
  task automatic test_random();
    logic          m_busy = 0, m_store = 0, m_checked = 0, m_ok = 0, m_excl = 0;
    logic [AW-1:0] m_addr = '0;
    logic [IW-1:0] m_id = '0;
    int            m_run = 0;
    logic          lr_pend = 0, st_pend = 0;
    logic          e_lr, e_st, e_chk, e_set, e_rsp;
    int            n_rsp = 0, n_lr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!lr_pend && $urandom_range(2) == 0) begin
        lr_pend = 1; lr_addr = AW'($urandom); lr_id = IW'($urandom);
      end
      if (!st_pend && $urandom_range(2) != 0) begin
        st_pend = 1; st_addr = AW'($urandom); st_id = IW'($urandom); st_excl = 1'($urandom);
      end
      lr_valid = lr_pend; st_valid = st_pend;
      set_gnt = ($urandom_range(2) != 0); check_clr_gnt = ($urandom_range(2) != 0);
      check_res = 1'($urandom); st_rsp_ready = 1'($urandom);
      #1;
      e_lr  = !m_busy && lr_valid && (!st_valid || m_run >= MS);
      e_st  = !m_busy && st_valid && !(lr_valid && m_run >= MS);
      e_chk = m_busy && m_store && !m_checked;
      e_set = m_busy && !m_store;
      e_rsp = m_busy && m_store && m_checked;
      n_cmp++;
      if ({lr_ready_o, st_ready_o, check_clr_req_o, set_req_o, st_rsp_valid_o} !==
          {e_lr, e_st, e_chk, e_set, e_rsp}) begin
        n_err++; $display("FAIL rnd_ctrl@%0d: got %b expected %b", cyc,
                          {lr_ready_o, st_ready_o, check_clr_req_o, set_req_o, st_rsp_valid_o},
                          {e_lr, e_st, e_chk, e_set, e_rsp});
      end
      if (e_chk) begin
        n_cmp++;
        if ({check_clr_addr_o, check_id_o, check_clr_excl_o} !== {m_addr, m_id, m_excl}) begin
          n_err++; $display("FAIL rnd_chk@%0d: got %h/%h/%b expected %h/%h/%b", cyc,
                            check_clr_addr_o, check_id_o, check_clr_excl_o, m_addr, m_id, m_excl);
        end
      end
      if (e_set) begin
        n_cmp++;
        if ({set_addr_o, set_id_o} !== {m_addr, m_id}) begin
          n_err++; $display("FAIL rnd_set@%0d: got %h/%h expected %h/%h", cyc, set_addr_o, set_id_o, m_addr, m_id);
        end
      end
      if (e_rsp) begin
        n_cmp++;
        if ({st_rsp_ok_o, st_rsp_id_o} !== {m_ok, m_id}) begin
          n_err++; $display("FAIL rnd_rsp@%0d: got ok=%b id=%h expected ok=%b id=%h", cyc,
                            st_rsp_ok_o, st_rsp_id_o, m_ok, m_id);
        end
      end
      if (e_lr || (!m_busy && !lr_valid)) m_run = 0;
      else if (e_st) m_run = (m_run < MS) ? m_run + 1 : MS;
      if (e_st) begin
        m_busy = 1; m_store = 1; m_checked = 0;
        m_addr = st_addr; m_id = st_id; m_excl = st_excl; st_pend = 0;
      end else if (e_lr) begin
        m_busy = 1; m_store = 0; m_addr = lr_addr; m_id = lr_id; lr_pend = 0; n_lr++;
      end else if (e_chk && check_clr_gnt) begin
        m_checked = 1; m_ok = check_res;
      end else if (e_set && set_gnt) begin
        m_busy = 0;
      end else if (e_rsp && st_rsp_ready) begin
        m_busy = 0; n_rsp++;
      end
    end
    n_cmp++;
    if (n_rsp == 0 || n_lr == 0) begin
      n_err++; $display("FAIL rnd_progress: got %0d responses %0d LRs expected both nonzero", n_rsp, n_lr);
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    test_reset();
    test_lone_lr();
    test_sc_after_lr();
    test_starvation();
    test_stall();
    test_simultaneous();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
